puf_eval_ctrl: RTL
==================

// Module: puf_eval_ctrl
// PURPOSE
//  Sequencer for the ring-oscillator PUF: turns one challenge into an N_BITS response.
//  For each bit it picks an RO pair, clears the pair counters and gates the oscillators
//  for a fixed window. It then compares the frozen counts and shifts in one response bit.
//  Sits between the host I/O and the RO banks, mux selects and edge counters.
// PARAMETERS
//  N_BITS     8   response bits produced per challenge (1..32)
//  CNT_W      16  width of the RO count inputs
//  WINDOW     16  clk cycles ro_en is held high per measurement (>=1)
//  SETTLE_CYC 4   clk cycles after ro_en falls before counts are sampled (>=1)
// PORTS
//  clk        in  1        system clock
//  rst_n      in  1        reset, asynchronous, active-high
//  start      in  1        request evaluation; accepted only in IDLE
//  challenge  in  5        base RO index, captured when start is accepted
//  busy       out 1        high in every state except IDLE
//  ro_en      out 1        oscillator enable (high only in RUN)
//  cnt_clr    out 1        counter clear pulse (high only in CLEAR)
//  sel_a      out 5        RO index for bank A
//  sel_b      out 5        RO index for bank B
//  cnt_a      in  CNT_W    bank A edge count, stable when ro_en=0 for SETTLE_CYC cycles
//  cnt_b      in  CNT_W    bank B edge count
//  resp       out N_BITS   response word, valid while resp_valid=1
//  resp_valid out 1        response available
//  resp_ready in  1        consumer accepts resp
//  err_sat    out 1        sticky: some sampled count was all-ones; cleared on next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; busy, ro_en, cnt_clr, resp_valid, err_sat = 0; resp, sel_a, sel_b = 0.
//   ro_en drops immediately (async). Reset mid-evaluation discards the partial response.
//  FSM: IDLE -> CLEAR -> RUN -> SETTLE -> COMPARE -> (CLEAR | DONE) -> IDLE.
//   IDLE:    on start=1, latch challenge, clear bit index k, clear resp and err_sat -> CLEAR.
//   CLEAR:   1 cycle, cnt_clr=1, ro_en=0.
//   RUN:     exactly WINDOW cycles, ro_en=1.
//   SETTLE:  exactly SETTLE_CYC cycles, ro_en=0.
//   COMPARE: 1 cycle; bit = (cnt_a > cnt_b) unsigned; tie -> 0; resp[k] <= bit.
//            Set err_sat if either count == {CNT_W{1'b1}}.
//            If k==N_BITS-1 -> DONE, else k++ -> CLEAR.
//   DONE:    resp_valid=1, resp held stable; on resp_ready=1 -> IDLE next cycle.
//  Pair selection for bit k (5-bit, modulo 32; wrap-around is legal):
//   sel_a = challenge + 2k
//   sel_b = challenge + 2k + 1
//   Both are registered and held constant from CLEAR through COMPARE.
//  Latency per bit L = WINDOW + SETTLE_CYC + 2 cycles.
//   resp_valid rises N_BITS*L cycles after the edge that accepts start (8*22=176 by default).
//  start while busy (including DONE) is ignored and never queued.
//  start and resp_ready both high in DONE: handshake completes, start is ignored.
//  resp_ready outside DONE has no effect.
//  challenge changes after acceptance have no effect.
// CONFIGURATION
//  PUF_MAJORITY_EN defined:
//   Each bit is measured 3 times (CLEAR/RUN/SETTLE/COMPARE x3, same pair).
//   resp[k] = majority of the 3 comparisons; err_sat accumulates over all 3.
//   Latency per bit = 3*L; default total = 528 cycles.
//  PUF_MAJORITY_EN undefined: single measurement per bit, as described above.
// TESTING
//  1. Assert rst_n mid-RUN at bit 3 -> ro_en/busy/resp_valid go 0 immediately; IDLE after release.
//  2. challenge=0, model cnt_a=100, cnt_b=50 for all bits -> resp=8'hFF;
//     resp_valid at +176 cycles; sel pairs (0,1)..(14,15).
//  3. challenge=5'd30, cnt_a=cnt_b=77 -> resp=8'h00; bit0 sel=(30,31), bit1 sel=(0,1) wrap.
//  4. Hold resp_ready=0 for 20 cycles in DONE with start=1 -> resp stable, no restart;
//     ready=1 -> IDLE next cycle.
//  5. Drive cnt_a=16'hFFFF on bit 2 only -> err_sat=1 at DONE; cleared on next accepted start.
//  6. PUF_MAJORITY_EN: bit 0 comparisons A>B, A<B, A>B -> resp[0]=1; resp_valid at +528 cycles.

Source files
------------

// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: ring-oscillator PUF evaluation sequencer.
// For every response bit it selects an RO pair, clears the pair counters,
// enables the oscillators for WINDOW cycles, waits SETTLE_CYC cycles for the
// counts to freeze, then compares them and shifts the result into resp.
// Optional feature: define PUF_MAJORITY_EN to measure each bit three times
// on the same pair and keep the majority of the three comparisons.
// Reset rst_n is asynchronous and active-high (the codebase's legacy naming).
module puf_eval_ctrl #(
  parameter int N_BITS     = 8,
  parameter int CNT_W      = 16,
  parameter int WINDOW     = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4:0]        challenge,
  output logic              busy,
  output logic              ro_en,
  output logic              cnt_clr,
  output logic [4:0]        sel_a,
  output logic [4:0]        sel_b,
  input  logic [CNT_W-1:0]  cnt_a,
  input  logic [CNT_W-1:0]  cnt_b,
  output logic [N_BITS-1:0] resp,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              err_sat
);

  localparam int K_W  = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int CMAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
  localparam int C_W  = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RUN, S_SETTLE, S_CMP, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [C_W-1:0]    cyc_q, cyc_d;
  logic [4:0]        sel_a_q, sel_a_d;
  logic [4:0]        sel_b_q, sel_b_d;
  logic [N_BITS-1:0] resp_q, resp_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              ro_en_q, ro_en_d;
  logic              clr_q, clr_d;
  logic              vld_q, vld_d;

  logic              cmp_bit;    // raw comparison of the frozen counts
  logic              cmp_sat;    // either count pegged at all-ones
  logic              bit_final;  // value written into resp[k]
  logic              bit_last;   // this COMPARE finishes bit k
`ifdef PUF_MAJORITY_EN
  logic [1:0]        rep_q, rep_d;
  logic [1:0]        votes_q, votes_d;
  logic [1:0]        votes_n;
`endif

  assign cmp_bit = (cnt_a > cnt_b);
  assign cmp_sat = (cnt_a == {CNT_W{1'b1}}) || (cnt_b == {CNT_W{1'b1}});

  // Next-state logic for the sequencer and its datapath registers.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cyc_d     = cyc_q;
    sel_a_d   = sel_a_q;
    sel_b_d   = sel_b_q;
    resp_d    = resp_q;
    err_d     = err_q;
    bit_final = 1'b0;
    bit_last  = 1'b0;
`ifdef PUF_MAJORITY_EN
    rep_d     = rep_q;
    votes_d   = votes_q;
    votes_n   = votes_q + {1'b0, cmp_bit};
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_a_d = challenge;
          sel_b_d = challenge + 5'd1;
          k_d     = '0;
          resp_d  = '0;
          err_d   = 1'b0;
          cyc_d   = '0;
`ifdef PUF_MAJORITY_EN
          rep_d   = '0;
          votes_d = '0;
`endif
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cyc_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (cyc_q == C_W'(WINDOW - 1)) begin
          cyc_d   = '0;
          state_d = S_SETTLE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (cyc_q == C_W'(SETTLE_CYC - 1)) begin
          cyc_d   = '0;
          state_d = S_CMP;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_CMP: begin
        if (cmp_sat) err_d = 1'b1;
`ifdef PUF_MAJORITY_EN
        // Third vote decides the bit; earlier votes just re-measure the pair.
        if (rep_q == 2'd2) begin
          bit_final = votes_n[1];
          bit_last  = 1'b1;
          rep_d     = '0;
          votes_d   = '0;
        end else begin
          rep_d   = rep_q + 2'd1;
          votes_d = votes_n;
          state_d = S_CLEAR;
        end
`else
        bit_final = cmp_bit;
        bit_last  = 1'b1;
`endif
        if (bit_last) begin
          resp_d[k_q] = bit_final;
          if (k_q == K_W'(N_BITS - 1)) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + 1'b1;
            sel_a_d = sel_a_q + 5'd2;
            sel_b_d = sel_b_q + 5'd2;
            state_d = S_CLEAR;
          end
        end
      end
      S_DONE: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave a flop directly.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    ro_en_d = (state_d == S_RUN);
    clr_d   = (state_d == S_CLEAR);
    vld_d   = (state_d == S_DONE);
  end

  // State and output registers; reset kills ro_en without waiting for clk.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cyc_q   <= '0;
      sel_a_q <= '0;
      sel_b_q <= '0;
      resp_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ro_en_q <= 1'b0;
      clr_q   <= 1'b0;
      vld_q   <= 1'b0;
`ifdef PUF_MAJORITY_EN
      rep_q   <= '0;
      votes_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cyc_q   <= cyc_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      ro_en_q <= ro_en_d;
      clr_q   <= clr_d;
      vld_q   <= vld_d;
`ifdef PUF_MAJORITY_EN
      rep_q   <= rep_d;
      votes_q <= votes_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign ro_en      = ro_en_q;
  assign cnt_clr    = clr_q;
  assign sel_a      = sel_a_q;
  assign sel_b      = sel_b_q;
  assign resp       = resp_q;
  assign resp_valid = vld_q;
  assign err_sat    = err_q;

endmodule
